// File: rtl/avgmax_pkg.sv
// Shared project package: avgmax FSM state encoding and default sizing constants.
package avgmax_pkg;

  localparam int unsigned DEF_NUM_WORDS = 16;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_RES_W     = 17;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/avgmax_unit_piso_shift.sv
// Parallel-in serial-out shifter, MSB first, with bit counter and last-bit flag.
module piso_shift #(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             bit_out,
  output logic             last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register drains to zero after a full frame, so the output idles low.
  assign bit_out = shreg_q[WIDTH-1];
  assign last_c  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/avgmax_unit.sv
// Reads NUM_WORDS SRAM words, tracks max and average, then streams {max, avg} serially.
module avgmax_unit
  import avgmax_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RES_W     = DEF_RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              avgmax_en,
  input  logic              ry,
  input  logic [31:0]       read_data,
  output logic              cs_n,
  output logic [ADDR_W-1:0] address,
  output logic              P_out,
  output logic              P_valid,
  output logic [RES_W-1:0]  max_out,
  output logic [RES_W-1:0]  avg_out,
  output logic              done
);

  localparam int unsigned CNT_W   = $clog2(NUM_WORDS);
  localparam int unsigned SUM_W   = RES_W + CNT_W;
  localparam int unsigned FRAME_W = 2 * RES_W;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [RES_W-1:0]   max_q, max_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               issue_d1_q;
  logic [RES_W-1:0]   max_out_q, max_out_d;
  logic [RES_W-1:0]   avg_out_q, avg_out_d;
  logic               p_valid_q, p_valid_d;
  logic               done_q, done_d;
  logic               issue_c;
  logic               load_c;
  logic               last_c;
  logic [RES_W-1:0]   word_c;
  logic [RES_W-1:0]   avg_c;
  logic               unused_read_data;

  assign issue_c          = (state_q == S_READ) && ry;
  assign word_c           = read_data[RES_W-1:0];
  assign unused_read_data = ^read_data;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    max_d     = max_q;
    sum_d     = sum_q;
    load_c    = 1'b0;

    // Data from the previous cycle's issue arrives now; DRAIN absorbs the last one.
    if (issue_d1_q) begin
      sum_d = sum_q + SUM_W'(word_c);
      if (word_c > max_q) max_d = word_c;
    end

    case (state_q)
      S_IDLE: begin
        if (avgmax_en) begin
          state_d  = S_READ;
          rd_cnt_d = '0;
          max_d    = '0;
          sum_d    = '0;
        end
      end
      S_READ: begin
        if (issue_c) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rd_cnt_q == CNT_W'(NUM_WORDS - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_SHIFT;
        load_c  = 1'b1;
      end
      S_SHIFT: begin
        if (last_c) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    avg_c     = RES_W'(sum_d >> CNT_W);
    max_out_d = load_c ? max_d : max_out_q;
    avg_out_d = load_c ? avg_c : avg_out_q;
    p_valid_d = (state_d == S_SHIFT);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      max_q      <= '0;
      sum_q      <= '0;
      issue_d1_q <= 1'b0;
      max_out_q  <= '0;
      avg_out_q  <= '0;
      p_valid_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      issue_d1_q <= issue_c;
      max_out_q  <= max_out_d;
      avg_out_q  <= avg_out_d;
      p_valid_q  <= p_valid_d;
      done_q     <= done_d;
    end
  end

  piso_shift #(
    .WIDTH (FRAME_W)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_data ({max_out_d, avg_out_d}),
    .shift_en  (state_q == S_SHIFT),
    .bit_out   (P_out),
    .last_c    (last_c)
  );

  // Chip select follows ry directly so a stalled cycle never issues a read.
  assign cs_n    = ~issue_c;
  assign address = ADDR_W'(rd_cnt_q);
  assign P_valid = p_valid_q;
  assign max_out = max_out_q;
  assign avg_out = avg_out_q;
  assign done    = done_q;

endmodule

// File: tb/tb_avgmax_unit.sv
// Self-checking bench for avgmax_unit: SRAM model, frame scoreboard, directed scenarios.
module tb_avgmax_unit;

  localparam int unsigned NW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 17;
  localparam int unsigned FW = 2 * RW;
  localparam int unsigned CW = $clog2(NW);

  logic          clk = 1'b0;
  logic          rst;
  logic          avgmax_en;
  logic          ry;
  logic [31:0]   read_data;
  logic          cs_n;
  logic [AW-1:0] address;
  logic          P_out;
  logic          P_valid;
  logic [RW-1:0] max_out;
  logic [RW-1:0] avg_out;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0]   mem [NW];
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] last_exp = '0;

  avgmax_unit #(.NUM_WORDS(NW), .ADDR_W(AW), .RES_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .avgmax_en (avgmax_en),
    .ry        (ry),
    .read_data (read_data),
    .cs_n      (cs_n),
    .address   (address),
    .P_out     (P_out),
    .P_valid   (P_valid),
    .max_out   (max_out),
    .avg_out   (avg_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  // SRAM with fixed one-cycle read latency
  always @(posedge clk) begin
    if (!cs_n) read_data <= mem[address[CW-1:0]];
  end

  task automatic model_push();
    logic [RW-1:0] mx;
    longint unsigned sum;
    logic [RW-1:0] w;
    mx  = '0;
    sum = 0;
    for (int i = 0; i < NW; i++) begin
      w = mem[i][RW-1:0];
      sum += longint'(w);
      if (w > mx) mx = w;
    end
    exp_q.push_back({mx, RW'(sum / NW)});
  endtask

  // One start pulse and full observation of the resulting frame.
  task automatic run_frame(input int stall_at, input int stall_len, input bit pulse_en,
                           input int abort_bit);
    logic [FW-1:0] frame;
    logic [FW-1:0] exp;
    int bits, first_v, done_cyc, cyc, extra;
    frame    = '0;
    bits     = 0;
    first_v  = -1;
    done_cyc = -1;
    extra    = (stall_at >= 0) ? stall_len : 0;
    if (abort_bit < 0) model_push();
    @(negedge clk);
    avgmax_en = 1'b1;
    ry        = 1'b1;
    @(posedge clk);
    #1;
    avgmax_en = 1'b0;
    cyc = 1;
    while (cyc <= 200 && done_cyc < 0) begin
      ry        = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      avgmax_en = pulse_en && (cyc == 5);
      @(negedge clk);
      if (!ry) begin
        vectors++;
        if (cs_n !== 1'b1 || address !== AW'(7)) begin
          miscompares++;
          $display("FAIL stall_cs cyc=%0d cs_n=%b addr=%0d required cs_n=1 addr=7", cyc, cs_n, address);
        end
      end
      if (P_valid) begin
        if (first_v < 0) first_v = cyc;
        frame = {frame[FW-2:0], P_out};
        bits++;
      end
      if (done) done_cyc = cyc;
      if (abort_bit >= 0 && bits == abort_bit + 1) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (P_valid !== 1'b0 || done !== 1'b0 || cs_n !== 1'b1 || max_out !== '0) begin
          miscompares++;
          $display("FAIL abort_state P_valid=%b done=%b cs_n=%b max=%0d required 0 0 1 0",
                   P_valid, done, cs_n, max_out);
        end
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    ry = 1'b1;
    if (abort_bit >= 0) return;

    vectors++;
    if (done_cyc !== NW + 2 + FW + extra) begin
      miscompares++;
      $display("FAIL done_cycle got %0d required %0d", done_cyc, NW + 2 + FW + extra);
    end
    vectors++;
    if (first_v !== NW + 2 + extra) begin
      miscompares++;
      $display("FAIL first_valid got %0d required %0d", first_v, NW + 2 + extra);
    end
    vectors++;
    if (bits !== FW) begin
      miscompares++;
      $display("FAIL bit_count got %0d required %0d", bits, FW);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty got frame %h required a queued entry", frame);
    end else begin
      exp      = exp_q.pop_front();
      last_exp = exp;
      if (frame !== exp) begin
        miscompares++;
        $display("FAIL frame got %h required %h", frame, exp);
      end
      vectors++;
      if (max_out !== exp[FW-1:RW] || avg_out !== exp[RW-1:0]) begin
        miscompares++;
        $display("FAIL results got max=%h avg=%h required max=%h avg=%h",
                 max_out, avg_out, exp[FW-1:RW], exp[RW-1:0]);
      end
    end
  endtask

  // Idle window: no frame activity, results held.
  task automatic check_quiet(input string tag, input int ncyc);
    int act;
    act = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (P_valid || done || !cs_n) act++;
    end
    vectors++;
    if (act !== 0) begin
      miscompares++;
      $display("FAIL %s_quiet got %0d active cycles required 0", tag, act);
    end
    vectors++;
    if ({max_out, avg_out} !== last_exp) begin
      miscompares++;
      $display("FAIL %s_hold got %h required %h", tag, {max_out, avg_out}, last_exp);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    avgmax_en = 1'b1;
    ry        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (cs_n !== 1'b1 || address !== '0 || P_out !== 1'b0 || P_valid !== 1'b0 ||
        done !== 1'b0 || max_out !== '0 || avg_out !== '0) begin
      miscompares++;
      $display("FAIL reset cs_n=%b addr=%0d P_out=%b P_valid=%b done=%b max=%0d avg=%0d required 1 0 0 0 0 0 0",
               cs_n, address, P_out, P_valid, done, max_out, avg_out);
    end
    avgmax_en = 1'b0;
    rst       = 1'b0;
    check_quiet("post_reset", 4);
  endtask

  task automatic test_ramp();
    for (int i = 0; i < NW; i++) mem[i] = 32'((i + 1) * 100);
    run_frame(-1, 0, 1'b0, -1);
    vectors++;
    if (max_out !== RW'(1600) || avg_out !== RW'(850)) begin
      miscompares++;
      $display("FAIL ramp_const got max=%0d avg=%0d required 1600 850", max_out, avg_out);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < NW; i++) mem[i] = 32'h0001_FFFF;
    run_frame(-1, 0, 1'b0, -1);
    vectors++;
    if (avg_out !== RW'(32'h1FFFF)) begin
      miscompares++;
      $display("FAIL saturate_avg got %h required 1ffff", avg_out);
    end
  endtask

  task automatic test_upper_bits();
    for (int i = 0; i < NW; i++) mem[i] = 32'hFFFE_0005;
    run_frame(-1, 0, 1'b0, -1);
    vectors++;
    if (max_out !== RW'(5) || avg_out !== RW'(5)) begin
      miscompares++;
      $display("FAIL upper_bits got max=%0d avg=%0d required 5 5", max_out, avg_out);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < NW; i++) mem[i] = 32'((i + 1) * 100);
    run_frame(8, 3, 1'b0, -1);
  endtask

  task automatic test_abort();
    for (int i = 0; i < NW; i++) mem[i] = 32'($urandom);
    run_frame(-1, 0, 1'b0, 10);
    last_exp = '0;
    check_quiet("abort", 60);
    run_frame(-1, 0, 1'b0, -1);
  endtask

  task automatic test_ignore_en();
    for (int i = 0; i < NW; i++) mem[i] = 32'($urandom);
    run_frame(-1, 0, 1'b1, -1);
    check_quiet("ignore_en", 80);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NW; i++) mem[i] = 32'($urandom) & 32'h0001_FFFF;
      if (k == 1) mem[3] = 32'h0001_FFFF;
      run_frame(-1, 0, 1'b0, -1);
    end
  endtask

  initial begin
    read_data = '0;
    rst       = 1'b1;
    avgmax_en = 1'b0;
    ry        = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    test_reset();
    test_ramp();
    test_saturate();
    test_upper_bits();
    test_stall();
    test_abort();
    test_ignore_en();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avgmax_unit.md
AVGMAX_UNIT -- requirements
Module: avgmax_unit

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 16: results read per frame, a power of two, from 2 to 256.
REQ-002 SHALL have parameter ADDR_W, default 8: SRAM word-address width.
REQ-003 SHALL have parameter RES_W, default 17: result width, matching MU1..MU4.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 avgmax_en  input  1  start pulse; sampled only in IDLE.
REQ-007 ry  input  1  SRAM ready; a read is issued only while high.
REQ-008 read_data  input  32  SRAM read word; result in [RES_W-1:0], upper bits ignored.
REQ-009 cs_n  output  1  SRAM chip select, active-low, one cycle per read.
REQ-010 address  output  ADDR_W  SRAM word address.
REQ-011 P_out  output  1  serial frame bit, MSB first.
REQ-012 P_valid  output  1  high on every cycle that P_out carries a frame bit.
REQ-013 max_out  output  RES_W  registered maximum of the last frame.
REQ-014 avg_out  output  RES_W  registered average of the last frame.
REQ-015 done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-016 SHALL implement the FSM IDLE -> READ -> DRAIN -> SHIFT -> DONE -> IDLE.
REQ-017 IDLE: when avgmax_en=1, clear the read counter, max accumulator and sum accumulator, then go to READ.
REQ-018 READ: while ry=1, drive cs_n=0 and address=rd_cnt, then increment rd_cnt. While ry=0, keep cs_n=1 and hold rd_cnt.
REQ-019 READ: after issuing address NUM_WORDS-1, go to DRAIN.
REQ-020 Read latency SHALL be fixed at 1: read_data is valid in the cycle after cs_n=0. Capture SHALL use a 1-cycle delayed issue flag.
REQ-021 Per captured word w = read_data[RES_W-1:0], unsigned:
- sum += w; sum width RES_W+log2(NUM_WORDS), so it cannot overflow.
- max = (w > max) ? w : max; ties keep the value, no effect.
REQ-022 DRAIN lasts exactly 1 cycle, absorbing the final capture. On exit:
- max_out <= max
- avg_out <= sum >> log2(NUM_WORDS), truncating.
REQ-023 SHIFT: serialise the 2*RES_W-bit frame {max_out, avg_out}, MSB first, one bit per cycle, with P_valid=1; then go to DONE.
REQ-024 DONE: done=1 for 1 cycle, then IDLE.
REQ-025 Latency: with ry held high, the first P_valid occurs NUM_WORDS+2 cycles after avgmax_en is sampled. The full operation ends with done at NUM_WORDS+2+2*RES_W.
REQ-026 avgmax_en outside IDLE SHALL be ignored; there is no queueing.
REQ-027 ry low mid-frame SHALL only stretch READ; results SHALL be unaffected.
REQ-028 Outside SHIFT, P_out=0 and P_valid=0. Outside READ issue cycles, cs_n=1.
REQ-029 max_out and avg_out SHALL hold until the next DRAIN.

Reset
REQ-030 rst=1 SHALL, at the next edge, force:
- state IDLE
- cs_n=1
- address=0, P_out=0, P_valid=0, done=0
- max_out=0, avg_out=0
- all counters and accumulators 0.
REQ-031 rst SHALL take priority over avgmax_en, and mid-operation SHALL abort without emitting done.

Structure
REQ-032 The FSM state encoding and the default NUM_WORDS, RES_W and ADDR_W constants SHALL live in the shared project package, used also by wb.
REQ-033 The serialiser SHALL be a sub-module, piso_shift: parallel load, shift enable, bit count, last-bit flag.

Verification
REQ-034 Words 0..15 = 100,200,...,1600, ry=1, start -> max_out=1600, avg_out=850; frame 0x00640 then 0x00352 as 34 bits; done at cycle 52.
REQ-035 All 16 words = 0x1FFFF -> max_out=0x1FFFF, avg_out=0x1FFFF, no overflow.
REQ-036 Upper bits set (read_data=0xFFFE0005 for all words) -> max_out=5, avg_out=5.
REQ-037 ry held low for 3 cycles at word 7 -> identical results; done 3 cycles later; cs_n=1 throughout the stall.
REQ-038 rst asserted during SHIFT bit 10 -> P_valid=0 and state IDLE next cycle, no done; a new start gives a correct full frame.
REQ-039 avgmax_en pulsed during READ -> ignored; a single frame is produced.
